// File: rtl/snes_pad_reader.sv
// SNES pad poller: strobes latch/clock, shifts in the 16-bit report and publishes 12 active-high buttons.
// Optional PAD_DEBOUNCE_EN: a button changes only when two consecutive good frames agree on it.
`timescale 1ns/1ps
module snes_pad_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833_333
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        pad_data,
  output logic        pad_latch,
  output logic        pad_clock,
  output logic [11:0] buttons,
  output logic        buttons_valid,
  output logic        frame_err
);
  localparam int PT_W   = $clog2(POLL_CYCLES);
  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);

  typedef enum logic [2:0] {IDLE, LATCH, CLK_HIGH, CLK_LOW, DONE} state_t;
  state_t state, state_next;

  logic [PT_W-1:0] poll_cnt;
  logic [PH_W-1:0] phase;
  logic [3:0]      bit_idx;
  logic [15:0]     raw;
  logic            data_p0, data_p1;
  logic            poll_wrap, latch_end, half_end, frame_good;
  logic [11:0]     decoded;
`ifdef PAD_DEBOUNCE_EN
  logic [11:0]     prev_good;
`endif

  assign poll_wrap  = (poll_cnt == PT_W'(POLL_CYCLES - 1));
  assign latch_end  = (phase == PH_W'(LATCH_CYCLES - 1));
  assign half_end   = (phase == PH_W'(HALF_CYCLES - 1));
  // A real pad always reports line-high in the four unused trailing bits.
  assign frame_good = &raw[15:12];
  assign decoded    = ~raw[11:0];

  // Synchronizer stages for the asynchronous pad line
  always_ff @(posedge clk) begin
    data_p0 <= pad_data;
    data_p1 <= data_p0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)         poll_cnt <= '0;
    else if (poll_wrap) poll_cnt <= '0;
    else                poll_cnt <= poll_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (poll_wrap) state_next = LATCH;
      LATCH:    if (latch_end) state_next = CLK_HIGH;
      CLK_HIGH: if (half_end)  state_next = CLK_LOW;
      CLK_LOW:  if (half_end)  state_next = (bit_idx == 4'd15) ? DONE : CLK_HIGH;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    pad_latch = 1'b0;
    pad_clock = 1'b1;
    case (state)
      LATCH:   pad_latch = 1'b1;
      CLK_LOW: pad_clock = 1'b0;
      default: ;
    endcase
  end

  // Shared phase counter restarts on every state change
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                                   phase <= '0;
    else if (state_next != state || state == IDLE) phase <= '0;
    else                                          phase <= phase + 1'b1;
  end

  // Shift-in and frame evaluation stage
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bit_idx       <= '0;
      raw           <= '0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
      frame_err     <= 1'b0;
`ifdef PAD_DEBOUNCE_EN
      prev_good     <= '0;
`endif
    end else begin
      buttons_valid <= (state == DONE) && frame_good;
      frame_err     <= (state == DONE) && !frame_good;
      if (state == LATCH)
        bit_idx <= '0;
      else if (state == CLK_LOW && half_end && bit_idx != 4'd15)
        bit_idx <= bit_idx + 1'b1;
      if (state == CLK_HIGH && half_end)
        raw[bit_idx] <= data_p1;
      if (state == DONE && frame_good) begin
`ifdef PAD_DEBOUNCE_EN
        // Take the new value only where it matches the previous good frame.
        buttons   <= (buttons & (decoded ^ prev_good)) | (decoded & ~(decoded ^ prev_good));
        prev_good <= decoded;
`else
        buttons   <= decoded;
`endif
      end
    end
  end
endmodule

// File: tb/tb_snes_pad_reader.sv
// Testbench for snes_pad_reader: behavioural pad model plus a frame-level reference of the button vector.
`timescale 1ns/1ps
module tb_snes_pad_reader;
  localparam int LC = 4, HC = 4, PC = 200;
  localparam int T_DONE = LC + 32 * HC + 1;
  localparam int T_FIRST_FALL = LC + HC;
  localparam int T_LAST_FALL = LC + HC + 15 * 2 * HC;

  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic        pad_data;
  logic        pad_latch, pad_clock, buttons_valid, frame_err;
  logic [11:0] buttons;

  snes_pad_reader #(.LATCH_CYCLES(LC), .HALF_CYCLES(HC), .POLL_CYCLES(PC)) dut (
    .clk(clk), .rst_l(rst_l), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clock(pad_clock),
    .buttons(buttons), .buttons_valid(buttons_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0, checks = 0, passed = 0;
  logic [15:0] report = 16'hFFFF;
  int          sh_idx = 16;
  logic        clk_q = 1'b1;

  // Pad: latch loads the report, each rising pad_clock shifts the next bit out.
  always @(negedge clk) begin
    if (pad_latch) sh_idx = 0;
    else if (pad_clock && !clk_q && sh_idx < 16) sh_idx = sh_idx + 1;
    clk_q = pad_clock;
    pad_data = (sh_idx < 16) ? report[sh_idx[3:0]] : 1'b1;
  end

  // Reference: expected button vector after each completed frame.
  logic [11:0] exp_buttons = '0;
`ifdef PAD_DEBOUNCE_EN
  logic [11:0] last_good = '0;
`endif

  task automatic model_reset();
    exp_buttons = '0;
`ifdef PAD_DEBOUNCE_EN
    last_good = '0;
`endif
  endtask

  task automatic model_frame(input logic [15:0] rep);
    logic [11:0] dec;
    if (rep[15:12] == 4'hF) begin
      dec = ~rep[11:0];
`ifdef PAD_DEBOUNCE_EN
      for (int i = 0; i < 12; i++)
        if (dec[i] == last_good[i]) exp_buttons[i] = dec[i];
      last_good = dec;
`else
      exp_buttons = dec;
`endif
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Observations of one poll period, from the latch rise through offset PC-1.
  int f_rise, f_latch_w, f_nfall, f_first_fall, f_last_fall, f_done, f_nvld, f_nerr, f_stray;
  bit f_timeout;

  task automatic capture_frame(input logic [15:0] rep);
    logic prev_l, prev_c;
    bit   found;
    report = rep;
    f_latch_w = 0; f_nfall = 0; f_first_fall = -1; f_last_fall = -1; f_done = -1;
    f_nvld = 0; f_nerr = 0; f_stray = 0; f_timeout = 0; f_rise = -1;
    prev_l = 1'b0; found = 0;
    for (int i = 0; i < 450 && !found; i++) begin
      step();
      if (pad_latch && !prev_l) found = 1;
      else begin
        if (buttons_valid || frame_err) f_stray++;
        prev_l = pad_latch;
      end
    end
    if (!found) begin
      f_timeout = 1;
      return;
    end
    f_rise = cyc; f_latch_w = 1; prev_c = pad_clock;
    for (int off = 1; off < PC; off++) begin
      step();
      if (pad_latch) f_latch_w++;
      if (prev_c && !pad_clock) begin
        f_nfall++;
        if (f_first_fall < 0) f_first_fall = off;
        f_last_fall = off;
      end
      prev_c = pad_clock;
      if (buttons_valid) begin f_nvld++; if (f_done < 0) f_done = off; end
      if (frame_err) begin f_nerr++; if (f_done < 0) f_done = off; end
    end
    model_frame(rep);
  endtask

  task automatic test_reset();
    int c0;
    #1 rst_l = 1'b0;
    model_reset();
    repeat (3) step();
    checks++; if (pad_latch !== 1'b0) $display("FAIL rst_latch: got %b want 0", pad_latch); else passed++;
    checks++; if (pad_clock !== 1'b1) $display("FAIL rst_clock: got %b want 1", pad_clock); else passed++;
    checks++; if (buttons !== 12'h000) $display("FAIL rst_buttons: got %h want 000", buttons); else passed++;
    checks++; if (buttons_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", buttons_valid); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL rst_err: got %b want 0", frame_err); else passed++;
    rst_l = 1'b1;
    c0 = cyc;
    capture_frame(16'hFFFF);
    checks++; if (f_timeout !== 1'b0) $display("FAIL rst_timeout: no latch within bound"); else passed++;
    checks++; if (f_rise - c0 !== PC) $display("FAIL rst_first_latch: got %0d want %0d", f_rise - c0, PC); else passed++;
    checks++; if (f_latch_w !== LC) $display("FAIL latch_width: got %0d want %0d", f_latch_w, LC); else passed++;
    checks++; if (f_nfall !== 16) $display("FAIL clock_falls: got %0d want 16", f_nfall); else passed++;
    checks++; if (f_first_fall !== T_FIRST_FALL) $display("FAIL first_fall: got %0d want %0d", f_first_fall, T_FIRST_FALL); else passed++;
    checks++; if (f_last_fall !== T_LAST_FALL) $display("FAIL last_fall: got %0d want %0d", f_last_fall, T_LAST_FALL); else passed++;
    checks++; if (f_done !== T_DONE) $display("FAIL valid_offset: got %0d want %0d", f_done, T_DONE); else passed++;
    checks++; if (f_nvld !== 1) $display("FAIL valid_count: got %0d want 1", f_nvld); else passed++;
    checks++; if (f_nerr !== 0) $display("FAIL err_count: got %0d want 0", f_nerr); else passed++;
    checks++; if (f_stray !== 0) $display("FAIL stray_pulse: got %0d want 0", f_stray); else passed++;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 2; k++) begin
      capture_frame(16'hFFFE);
      checks++; if (f_nvld !== 1) $display("FAIL basic_valid: got %0d want 1", f_nvld); else passed++;
      checks++; if (f_nerr !== 0) $display("FAIL basic_err: got %0d want 0", f_nerr); else passed++;
      checks++; if (buttons !== exp_buttons) $display("FAIL basic_buttons: got %h want %h", buttons, exp_buttons); else passed++;
    end
    checks++; if (buttons !== 12'h001) $display("FAIL basic_b_only: got %h want 001", buttons); else passed++;
  endtask

  task automatic test_absent();
    capture_frame(16'h0FFF);
    checks++; if (f_nerr !== 1) $display("FAIL absent_err: got %0d want 1", f_nerr); else passed++;
    checks++; if (f_nvld !== 0) $display("FAIL absent_valid: got %0d want 0", f_nvld); else passed++;
    checks++; if (f_done !== T_DONE) $display("FAIL absent_offset: got %0d want %0d", f_done, T_DONE); else passed++;
    checks++; if (buttons !== exp_buttons) $display("FAIL absent_hold: got %h want %h", buttons, exp_buttons); else passed++;
  endtask

  task automatic test_random();
    logic [15:0] rep;
    bit good;
    for (int k = 0; k < 8; k++) begin
      good = ($urandom_range(0, 3) != 0);
      rep = 16'($urandom);
      if (good) rep[15:12] = 4'hF;
      else if (rep[15:12] == 4'hF) rep[12] = 1'b0;
      capture_frame(rep);
      checks++; if (f_nvld !== (good ? 1 : 0)) $display("FAIL rand_valid: rep %h got %0d want %0d", rep, f_nvld, good ? 1 : 0); else passed++;
      checks++; if (f_nerr !== (good ? 0 : 1)) $display("FAIL rand_err: rep %h got %0d want %0d", rep, f_nerr, good ? 0 : 1); else passed++;
      checks++; if (buttons !== exp_buttons) $display("FAIL rand_buttons: rep %h got %h want %h", rep, buttons, exp_buttons); else passed++;
    end
  endtask

  task automatic test_left();
    logic [15:0] seq [5] = '{16'hFFFF, 16'hFFFF, 16'hFFBF, 16'hFFFF, 16'hFFBF};
`ifdef PAD_DEBOUNCE_EN
    logic left_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic left_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int k = 0; k < 5; k++) begin
      capture_frame(seq[k]);
      checks++; if (buttons[6] !== left_exp[k]) $display("FAIL left_bit frame %0d: got %b want %b", k, buttons[6], left_exp[k]); else passed++;
      checks++; if (buttons !== exp_buttons) $display("FAIL left_vector frame %0d: got %h want %h", k, buttons, exp_buttons); else passed++;
    end
    capture_frame(16'hFFBF);
    checks++; if (buttons[6] !== 1'b1) $display("FAIL left_held: got %b want 1", buttons[6]); else passed++;
  endtask

  task automatic test_reset_mid();
    logic prev_l;
    bit   found;
    int   c0;
    capture_frame(16'hF5A5);
    capture_frame(16'hF5A5);
    checks++; if (buttons !== exp_buttons) $display("FAIL mid_pre_buttons: got %h want %h", buttons, exp_buttons); else passed++;
    report = 16'hFFFF;
    prev_l = 1'b0; found = 0;
    for (int i = 0; i < 450 && !found; i++) begin
      step();
      if (pad_latch && !prev_l) found = 1;
      prev_l = pad_latch;
    end
    checks++; if (!found) $display("FAIL mid_latch_timeout: no latch within bound"); else passed++;
    repeat (LC + 15 * HC + 2) step();
    checks++; if (pad_clock !== 1'b0) $display("FAIL mid_in_low_phase: got %b want 0", pad_clock); else passed++;
    #2 rst_l = 1'b0;
    #1;
    model_reset();
    checks++; if (pad_clock !== 1'b1) $display("FAIL mid_clock: got %b want 1", pad_clock); else passed++;
    checks++; if (pad_latch !== 1'b0) $display("FAIL mid_latch: got %b want 0", pad_latch); else passed++;
    checks++; if (buttons !== 12'h000) $display("FAIL mid_buttons: got %h want 000", buttons); else passed++;
    checks++; if (buttons_valid !== 1'b0 || frame_err !== 1'b0) $display("FAIL mid_pulses: got %b%b want 00", buttons_valid, frame_err); else passed++;
    repeat (3) step();
    rst_l = 1'b1;
    c0 = cyc;
    capture_frame(16'hFFFE);
    checks++; if (f_rise - c0 !== PC) $display("FAIL mid_next_latch: got %0d want %0d", f_rise - c0, PC); else passed++;
    checks++; if (f_stray !== 0) $display("FAIL mid_partial_frame: got %0d pulses want 0", f_stray); else passed++;
    checks++; if (f_nvld !== 1) $display("FAIL mid_valid: got %0d want 1", f_nvld); else passed++;
    checks++; if (buttons !== exp_buttons) $display("FAIL mid_after_buttons: got %h want %h", buttons, exp_buttons); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rep;
    int prev_rise = -1;
    for (int k = 0; k < 3; k++) begin
      rep = {4'hF, 12'($urandom)};
      capture_frame(rep);
      checks++; if (f_timeout !== 1'b0) $display("FAIL b2b_timeout frame %0d", k); else passed++;
      if (k > 0) begin
        checks++; if (f_rise - prev_rise !== PC) $display("FAIL b2b_period: got %0d want %0d", f_rise - prev_rise, PC); else passed++;
      end
      prev_rise = f_rise;
      checks++; if (f_done !== T_DONE) $display("FAIL b2b_offset: got %0d want %0d", f_done, T_DONE); else passed++;
      checks++; if (f_nvld !== 1 || f_stray !== 0) $display("FAIL b2b_valid_count: got %0d+%0d want 1+0", f_nvld, f_stray); else passed++;
      checks++; if (buttons !== exp_buttons) $display("FAIL b2b_buttons: got %h want %h", buttons, exp_buttons); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_absent();
    test_random();
    test_left();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end
endmodule
